// File: rtl/level_sequencer_pkg.sv
// ddr_pkg: shared FSM state codes, arrow direction bit positions and ms counter width for the DDR core.
package ddr_pkg;
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ARM  = 3'd1;
   localparam logic [2:0] S_PLAY = 3'd2;
   localparam logic [2:0] S_GAP  = 3'd3;
   localparam logic [2:0] S_OVER = 3'd4;
   localparam int DIR_LEFT  = 3;
   localparam int DIR_RIGHT = 2;
   localparam int DIR_UP    = 1;
   localparam int DIR_DOWN  = 0;
   localparam int MS_W = 16;
endpackage

// File: rtl/level_sequencer_if.sv
// level_sequencer_if: start button, level generator bank and display/judge signals of the level sequencer.
interface level_sequencer_if #(parameter int NUM_LEVELS = 3) ();
   logic                  start_game;
   logic [NUM_LEVELS-1:0] lvl_left, lvl_right, lvl_up, lvl_down, lvl_done, lvl_start;
   logic                  left, right, up, down, playing, game_over;
   logic [1:0]            level;
   modport master (output start_game, lvl_left, lvl_right, lvl_up, lvl_down, lvl_done,
                   input lvl_start, left, right, up, down, level, playing, game_over);
   modport slave (input start_game, lvl_left, lvl_right, lvl_up, lvl_down, lvl_done,
                  output lvl_start, left, right, up, down, level, playing, game_over);
endinterface

// File: rtl/level_sequencer_ms_tick.sv
// ms_tick: free-running prescaler emitting a one-cycle tick every TICK_DIV clocks; clr restarts the count.
module ms_tick #(parameter int TICK_DIV = 50000) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   logic [W-1:0] cnt_q;
   assign tick = cnt_q == W'(TICK_DIV - 1);
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt_q <= '0;
      else      cnt_q <= (clr || tick) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: game-flow FSM that arms each level in turn, routes the active level's arrows
// and advances on done or a millisecond watchdog, with an intermission between levels.
module level_sequencer
   import ddr_pkg::*;
#(
   parameter int NUM_LEVELS = 3,
   parameter int TICK_DIV   = 50000,
   parameter int GAP_MS     = 2000,
   parameter int TIMEOUT_MS = 31000
) (
   input logic clk,
   input logic rst,
   level_sequencer_if.slave bus
);
   logic [2:0]      state_q, state_d;
   logic [1:0]      level_q, level_d;
   logic [MS_W-1:0] ms_q, ms_d, ms_inc;
   logic [3:0]      arrow_q, arrow_d;
   logic [3:0]      left_w, right_w, up_w, down_w, done_w;
   logic            tick, in_play, last, adv;
   ms_tick #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .clr(state_q == S_ARM), .tick(tick));
   // Pad the per-level vectors to four bits so a 2-bit level index is always in range.
   assign left_w  = 4'(bus.lvl_left);
   assign right_w = 4'(bus.lvl_right);
   assign up_w    = 4'(bus.lvl_up);
   assign down_w  = 4'(bus.lvl_down);
   assign done_w  = 4'(bus.lvl_done);
   assign in_play = state_q == S_PLAY;
   assign last    = level_q == 2'(NUM_LEVELS - 1);
   assign adv     = in_play && (done_w[level_q] || ms_q == MS_W'(TIMEOUT_MS));
   assign ms_inc  = (tick && ms_q != '1) ? ms_q + 1'b1 : ms_q;
   always_comb begin
      arrow_d            = '0;
      arrow_d[DIR_LEFT]  = in_play & left_w[level_q];
      arrow_d[DIR_RIGHT] = in_play & right_w[level_q];
      arrow_d[DIR_UP]    = in_play & up_w[level_q];
      arrow_d[DIR_DOWN]  = in_play & down_w[level_q];
   end
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      ms_d    = ms_q;
      case (state_q)
         S_IDLE, S_OVER: if (bus.start_game) begin
            state_d = S_ARM;
            level_d = '0;
         end
         S_ARM: begin
            state_d = S_PLAY;
            ms_d    = '0;
         end
         S_PLAY: begin
            ms_d    = adv ? '0 : ms_inc;
            state_d = !adv ? S_PLAY : last ? S_OVER : S_GAP;
         end
         S_GAP: if (ms_q == MS_W'(GAP_MS)) begin
            state_d = S_ARM;
            level_d = level_q + 1'b1;
         end else begin
            ms_d = ms_inc;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= S_IDLE;
         level_q <= '0;
         ms_q    <= '0;
         arrow_q <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         ms_q    <= ms_d;
         arrow_q <= arrow_d;
      end
   assign bus.lvl_start = state_q == S_ARM ? NUM_LEVELS'(4'b0001 << level_q) : '0;
   assign bus.left      = arrow_q[DIR_LEFT];
   assign bus.right     = arrow_q[DIR_RIGHT];
   assign bus.up        = arrow_q[DIR_UP];
   assign bus.down      = arrow_q[DIR_DOWN];
   assign bus.level     = level_q;
   assign bus.playing   = in_play;
   assign bus.game_over = state_q == S_OVER;
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: vector table with an arrow scoreboard plus hand-written sequences for
// start, done/watchdog advance, intermission, game over, restart and asynchronous abort.
module tb_level_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int checks = 0;
   int failures = 0;
   logic [3:0] exp_q[$];
   level_sequencer_if #(.NUM_LEVELS(3)) bus ();
   level_sequencer #(.NUM_LEVELS(3), .TICK_DIV(4), .GAP_MS(5), .TIMEOUT_MS(20)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [2:0] l, r, u, d, done;
      logic [3:0] exp_arrows;
      logic       exp_play;
   } vec_t;
   vec_t tbl[7];
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic int arrows();
      return {bus.left, bus.right, bus.up, bus.down};
   endfunction
   task automatic wait_start(input string name, input int exp_start, output int n);
      n = 0;
      while (bus.lvl_start == 0 && n < 200) begin
         step();
         n++;
      end
      chk(name, int'(bus.lvl_start), exp_start);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1, "timeout");
   end
   initial begin
      int n, m;
      logic [3:0] e;
      tbl[0] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 4'b0010, 1'b1};
      tbl[1] = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 4'b0000, 1'b1};
      tbl[2] = '{3'b001, 3'b100, 3'b000, 3'b000, 3'b000, 4'b1000, 1'b1};
      tbl[3] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b110, 4'b1111, 1'b1};
      tbl[4] = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b010, 4'b0000, 1'b1};
      tbl[5] = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b100, 4'b0101, 1'b1};
      tbl[6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 4'b0000, 1'b1};
      bus.start_game = 0;
      bus.lvl_left = 0; bus.lvl_right = 0; bus.lvl_up = 0; bus.lvl_down = 0; bus.lvl_done = 0;
      repeat (3) step();
      chk("reset_playing", bus.playing, 0);
      rst = 1;
      repeat (100) step();
      chk("idle_lvl_start", int'(bus.lvl_start), 0);
      chk("idle_arrows", arrows(), 0);
      chk("idle_playing", bus.playing, 0);
      chk("idle_game_over", bus.game_over, 0);
      chk("idle_level", bus.level, 0);
      bus.start_game = 1;
      step();
      chk("arm_lvl_start", int'(bus.lvl_start), 1);
      chk("arm_playing", bus.playing, 0);
      bus.start_game = 0;
      step();
      chk("play_lvl_start", int'(bus.lvl_start), 0);
      chk("play_playing", bus.playing, 1);
      foreach (tbl[i]) begin
         bus.lvl_left = tbl[i].l; bus.lvl_right = tbl[i].r;
         bus.lvl_up = tbl[i].u; bus.lvl_down = tbl[i].d; bus.lvl_done = tbl[i].done;
         exp_q.push_back(tbl[i].exp_arrows);
         step();
         e = exp_q.pop_front();
         chk($sformatf("vec%0d_arrows", i), arrows(), int'(e));
         chk($sformatf("vec%0d_playing", i), bus.playing, int'(tbl[i].exp_play));
      end
      bus.lvl_done = 3'b001; bus.lvl_up = 3'b001;
      step();
      chk("done0_playing", bus.playing, 0);
      chk("done0_last_arrow", bus.up, 1);
      bus.lvl_done = 0; bus.start_game = 1;
      step();
      chk("gap_arrow_mask", bus.up, 0);
      wait_start("gap_to_arm1", 3'b010, n);
      chk("gap_len_ok", int'(n + 1 >= 18 && n + 1 <= 21), 1);
      chk("arm1_level", bus.level, 1);
      step();
      chk("play1_playing", bus.playing, 1);
      chk("play1_start_ignored", bus.level, 1);
      bus.start_game = 0; bus.lvl_up = 0;
      m = 0;
      while (bus.playing && m < 200) begin
         step();
         m++;
      end
      chk("watchdog_len_ok", int'(m + 1 >= 80 && m + 1 <= 82), 1);
      chk("watchdog_level", bus.level, 1);
      chk("watchdog_not_over", bus.game_over, 0);
      wait_start("gap_to_arm2", 3'b100, n);
      chk("arm2_level", bus.level, 2);
      step();
      bus.lvl_done = 3'b100;
      step();
      chk("over_game_over", bus.game_over, 1);
      chk("over_level", bus.level, 2);
      bus.lvl_done = 3'b111;
      repeat (10) step();
      bus.lvl_done = 0;
      chk("over_held", bus.game_over, 1);
      chk("over_level_held", bus.level, 2);
      chk("over_no_start", int'(bus.lvl_start), 0);
      bus.start_game = 1;
      step();
      chk("restart_lvl_start", int'(bus.lvl_start), 1);
      chk("restart_level", bus.level, 0);
      bus.start_game = 0;
      step();
      bus.lvl_done = 3'b001;
      step();
      bus.lvl_done = 0;
      wait_start("re_arm1", 3'b010, n);
      repeat (81) step();
      chk("coinc_still_playing", bus.playing, 1);
      bus.lvl_done = 3'b010;
      step();
      bus.lvl_done = 0;
      chk("coinc_playing", bus.playing, 0);
      chk("coinc_not_over", bus.game_over, 0);
      chk("coinc_level", bus.level, 1);
      wait_start("coinc_arm2", 3'b100, n);
      chk("coinc_arm2_level", bus.level, 2);
      step();
      bus.lvl_done = 3'b100;
      step();
      bus.lvl_done = 0; bus.start_game = 1;
      step();
      bus.start_game = 0;
      step();
      bus.lvl_done = 3'b001;
      step();
      bus.lvl_done = 0;
      wait_start("abort_arm1", 3'b010, n);
      step();
      bus.lvl_up = 3'b010;
      step();
      chk("route_lvl1_up", bus.up, 1);
      #2 rst = 0;
      #1;
      chk("abort_arrows", arrows(), 0);
      chk("abort_playing", bus.playing, 0);
      chk("abort_level", bus.level, 0);
      chk("abort_lvl_start", int'(bus.lvl_start), 0);
      bus.lvl_up = 0;
      repeat (2) step();
      rst = 1;
      repeat (5) step();
      chk("abort_idle", bus.playing, 0);
      bus.start_game = 1;
      step();
      bus.start_game = 0;
      chk("abort_restart_start", int'(bus.lvl_start), 1);
      chk("abort_restart_level", bus.level, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
